controle_hazard_id: RTL

CONTROLE_HAZARD_ID -- requirements
Module: controle_hazard_id

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/detector_dependencia.sv | 24 ++
 rtl/controle_hazard_id.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-control FSM encodings, default counter width
// and the register-dependency predicate used by the ID-stage hazard unit.
package pipeline_pkg;

    localparam logic [1:0] ESTADO_RUN   = 2'b00;
    localparam logic [1:0] ESTADO_STALL = 2'b01;

    localparam int LARGURA_CONT_PADRAO = 16;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bolha;
    } controle_t;

    localparam controle_t CONTROLE_LIVRE = '{pc_write: 1'b1, ifid_write: 1'b1,
                                             ifid_flush: 1'b0, idex_bolha: 1'b0};

    // Register $zero is never a real producer, so it can never create a dependency.
    function automatic logic fonte_depende(input logic [4:0] fonte,
                                           input logic [4:0] destino,
                                           input logic       escreve);
        return escreve && (fonte != 5'd0) && (fonte == destino);
    endfunction

endpackage

// File: rtl/detector_dependencia.sv
// Combinational comparator: flags whether the ID sources depend on the EX or MEM destination.
module detector_dependencia
    import pipeline_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_usa_rt,
    input  logic [4:0] ex_dest,
    input  logic       ex_regWrite,
    input  logic [4:0] mem_dest,
    input  logic       mem_regWrite,
    output logic       dep_ex,
    output logic       dep_mem
);

    // rt only participates when the instruction actually reads it
    always_comb begin
        dep_ex  = fonte_depende(id_rs, ex_dest, ex_regWrite)
                || (id_usa_rt && fonte_depende(id_rt, ex_dest, ex_regWrite));
        dep_mem = fonte_depende(id_rs, mem_dest, mem_regWrite)
                || (id_usa_rt && fonte_depende(id_rt, mem_dest, mem_regWrite));
    end

endmodule

// File: rtl/controle_hazard_id.sv
// ID-stage hazard controller: stall FSM, branch/jump flush and saturating stall counter.
// Build option: define FORWARDING_EN to stall only on load-use hazards.
module controle_hazard_id
    import pipeline_pkg::*;
#(
    parameter int LARGURA_CONT = LARGURA_CONT_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic                    id_usa_rt,
    input  logic                    id_jump,
    input  logic [4:0]              ex_dest,
    input  logic                    ex_regWrite,
    input  logic                    ex_memRead,
    input  logic [4:0]              mem_dest,
    input  logic                    mem_regWrite,
    input  logic                    ex_branch_taken,
    output logic                    pc_write,
    output logic                    ifid_write,
    output logic                    ifid_flush,
    output logic                    idex_bolha,
    output logic [1:0]              estado,
    output logic [LARGURA_CONT-1:0] contador_stalls
);

    logic                    dep_ex_s;
    logic                    dep_mem_s;
    logic                    load_uso_s;
    logic [1:0]              n_stall_s;
    logic [1:0]              estado_r;
    logic [1:0]              estado_prox_s;
    logic [1:0]              restante_r;
    logic [1:0]              restante_prox_s;
    controle_t               ctrl_s;
    logic [LARGURA_CONT-1:0] contador_r;

    detector_dependencia u_detector (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_usa_rt    (id_usa_rt),
        .ex_dest      (ex_dest),
        .ex_regWrite  (ex_regWrite),
        .mem_dest     (mem_dest),
        .mem_regWrite (mem_regWrite),
        .dep_ex       (dep_ex_s),
        .dep_mem      (dep_mem_s)
    );

    // Stall length demanded by the instruction currently in ID
    always_comb begin
        load_uso_s = ex_memRead && dep_ex_s;
        n_stall_s  = 2'd0;
`ifdef FORWARDING_EN
        if (load_uso_s) begin
            n_stall_s = 2'd1;
        end else begin
            n_stall_s = 2'd0;
        end
`else
        if (dep_ex_s || load_uso_s) begin
            n_stall_s = 2'd2;
        end else if (dep_mem_s) begin
            n_stall_s = 2'd1;
        end else begin
            n_stall_s = 2'd0;
        end
`endif
    end

    // Next state, remaining stall cycles and pipeline control; a taken branch overrides all
    always_comb begin
        estado_prox_s   = estado_r;
        restante_prox_s = restante_r;
        ctrl_s          = CONTROLE_LIVRE;
        if (ex_branch_taken) begin
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_bolha = 1'b1;
            estado_prox_s     = ESTADO_RUN;
            restante_prox_s   = 2'd0;
        end else begin
            case (estado_r)
                ESTADO_RUN: begin
                    if (n_stall_s != 2'd0) begin
                        ctrl_s.pc_write   = 1'b0;
                        ctrl_s.ifid_write = 1'b0;
                        ctrl_s.idex_bolha = 1'b1;
                        restante_prox_s   = n_stall_s - 2'd1;
                        if (n_stall_s > 2'd1) begin
                            estado_prox_s = ESTADO_STALL;
                        end else begin
                            estado_prox_s = ESTADO_RUN;
                        end
                    end else if (id_jump) begin
                        ctrl_s.ifid_flush = 1'b1;
                    end else begin
                        ctrl_s = CONTROLE_LIVRE;
                    end
                end
                ESTADO_STALL: begin
                    ctrl_s.pc_write   = 1'b0;
                    ctrl_s.ifid_write = 1'b0;
                    ctrl_s.idex_bolha = 1'b1;
                    // a corrupted zero count also exits rather than wrapping
                    if (restante_r <= 2'd1) begin
                        restante_prox_s = 2'd0;
                        estado_prox_s   = ESTADO_RUN;
                    end else begin
                        restante_prox_s = restante_r - 2'd1;
                        estado_prox_s   = ESTADO_STALL;
                    end
                end
                default: begin
                    estado_prox_s   = ESTADO_RUN;
                    restante_prox_s = 2'd0;
                end
            endcase
        end
    end

    // Outputs fall back to free-running values whenever reset is held
    always_comb begin
        if (!reset_n) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
            idex_bolha = 1'b0;
        end else begin
            pc_write   = ctrl_s.pc_write;
            ifid_write = ctrl_s.ifid_write;
            ifid_flush = ctrl_s.ifid_flush;
            idex_bolha = ctrl_s.idex_bolha;
        end
    end

    // FSM state and remaining-stall register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_r   <= ESTADO_RUN;
            restante_r <= 2'd0;
        end else begin
            estado_r   <= estado_prox_s;
            restante_r <= restante_prox_s;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contador_r <= '0;
        end else if (!pc_write && (contador_r != {LARGURA_CONT{1'b1}})) begin
            contador_r <= contador_r + LARGURA_CONT'(1);
        end else begin
            contador_r <= contador_r;
        end
    end

    assign estado          = estado_r;
    assign contador_stalls = contador_r;

endmodule
